// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between inst fetch and data; data has priority, a starvation counter forces inst progress.
// Zero-cycle request/response paths; one transaction outstanding, so both requesters stall (addr_ok=0) while BUSY.
module sram_bus_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;

   logic is_idle;
   logic grant_data;
   logic grant_inst;
   logic accept;

   always_comb begin
      is_idle    = (state_q == IDLE);
      grant_data = is_idle && data_req && !(inst_req && (starve_cnt_q == LIMIT));
      grant_inst = is_idle && !grant_data && inst_req;
      accept     = (grant_data || grant_inst) && mem_addr_ok;

      mem_req      = grant_data || grant_inst;
      inst_addr_ok = grant_inst && mem_addr_ok;
      data_addr_ok = grant_data && mem_addr_ok;

      // Fields follow the data side unless inst is the one being granted.
      if (grant_inst) begin
         mem_wr    = inst_wr;
         mem_size  = inst_size;
         mem_addr  = inst_addr;
         mem_wstrb = inst_wstrb;
         mem_wdata = inst_wdata;
      end else begin
         mem_wr    = data_wr;
         mem_size  = data_size;
         mem_addr  = data_addr;
         mem_wstrb = data_wstrb;
         mem_wdata = data_wdata;
      end

      inst_data_ok = !is_idle && !owner_q && mem_data_ok;
      data_data_ok = !is_idle && owner_q && mem_data_ok;
      inst_rdata   = mem_rdata;
      data_rdata   = mem_rdata;
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      starve_cnt_d = starve_cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = BUSY;
               owner_d = grant_data;
               // Only a data win over a waiting fetch counts toward starvation.
               if (grant_data && inst_req) begin
                  starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
               end else begin
                  starve_cnt_d = 4'd0;
               end
            end
         end
         BUSY: begin
            if (mem_data_ok) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         starve_cnt_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a transaction-level model of the arbitration rules.
module tb_sram_bus_arbiter;

   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic [3:0]  inst_wstrb, data_wstrb;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        mem_addr_ok, mem_data_ok;

   int total = 0;
   int bad   = 0;

   sram_bus_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: one outstanding transaction, its owner, and how many data grants in a row
   // have overtaken a waiting fetch.
   bit m_busy   = 0;
   bit m_owner  = 0;
   int m_streak = 0;
   bit acc_i = 0, acc_d = 0, fin = 0;

   always @(negedge clk) begin
      bit blocked, e_gd, e_gi;
      if (reset) begin
         m_busy = 0; m_owner = 0; m_streak = 0;
      end
      blocked = inst_req && (m_streak >= LIM);
      e_gd = !m_busy && data_req && !blocked;
      e_gi = !m_busy && !e_gd && inst_req;
      chk("mem_req", 32'(mem_req), 32'(e_gd || e_gi));
      chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_gi && mem_addr_ok));
      chk("data_addr_ok", 32'(data_addr_ok), 32'(e_gd && mem_addr_ok));
      chk("inst_data_ok", 32'(inst_data_ok), 32'(m_busy && !m_owner && mem_data_ok));
      chk("data_data_ok", 32'(data_data_ok), 32'(m_busy && m_owner && mem_data_ok));
      if (e_gd || e_gi) begin
         chk("mem_wr",    32'(mem_wr),    32'(e_gi ? inst_wr    : data_wr));
         chk("mem_size",  32'(mem_size),  32'(e_gi ? inst_size  : data_size));
         chk("mem_addr",  mem_addr,       e_gi ? inst_addr  : data_addr);
         chk("mem_wstrb", 32'(mem_wstrb), 32'(e_gi ? inst_wstrb : data_wstrb));
         chk("mem_wdata", mem_wdata,      e_gi ? inst_wdata : data_wdata);
      end
      if (m_busy && mem_data_ok && !m_owner) chk("inst_rdata", inst_rdata, mem_rdata);
      if (m_busy && mem_data_ok && m_owner)  chk("data_rdata", data_rdata, mem_rdata);
      acc_i = !reset && e_gi && mem_addr_ok;
      acc_d = !reset && e_gd && mem_addr_ok;
      fin   = !reset && m_busy && mem_data_ok;
   end

   always @(posedge clk) begin
      if (reset) begin
         m_busy = 0; m_owner = 0; m_streak = 0;
      end else if (acc_i || acc_d) begin
         m_busy  = 1;
         m_owner = acc_d;
         if (acc_d && inst_req) m_streak = (m_streak + 1 > LIM) ? LIM : m_streak + 1;
         else m_streak = 0;
      end else if (fin) begin
         m_busy = 0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic probe();
      @(negedge clk);
      #1;
   endtask

   task automatic quiet();
      inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
   endtask

   initial begin
      string order;
      reset = 1;
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wstrb = '0; inst_wdata = '0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wstrb = '0; data_wdata = '0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
      repeat (3) cyc();
      reset = 0;

      // Reset then idle, plus a spurious response while nothing is outstanding.
      for (int i = 0; i < 10; i++) begin
         cyc();
         mem_data_ok = (i == 7);
         probe();
         chk("idle_mem_req", 32'(mem_req), 32'd0);
         chk("idle_oks", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
      end

      // Single fetch.
      cyc();
      quiet();
      inst_req = 1; inst_wr = 0; inst_addr = 32'hbfc00000; inst_size = 2'd2; mem_addr_ok = 1;
      probe();
      chk("fetch_addr_ok", 32'(inst_addr_ok), 32'd1);
      chk("fetch_mem_addr", mem_addr, 32'hbfc00000);
      chk("fetch_data_side", 32'(data_addr_ok), 32'd0);
      cyc();
      quiet(); mem_data_ok = 1; mem_rdata = 32'h24080001;
      probe();
      chk("fetch_data_ok", 32'(inst_data_ok), 32'd1);
      chk("fetch_rdata", inst_rdata, 32'h24080001);
      chk("fetch_data_side_ok", 32'(data_data_ok), 32'd0);

      // Priority: data write wins, inst follows once the write completes.
      cyc();
      quiet();
      inst_req = 1; inst_addr = 32'hbfc00004;
      data_req = 1; data_wr = 1; data_addr = 32'h80001000; data_wstrb = 4'hF; data_wdata = 32'hdeadbeef;
      mem_addr_ok = 1;
      probe();
      chk("prio_mem_wr", 32'(mem_wr), 32'd1);
      chk("prio_mem_addr", mem_addr, 32'h80001000);
      chk("prio_mem_wdata", mem_wdata, 32'hdeadbeef);
      chk("prio_data_addr_ok", 32'(data_addr_ok), 32'd1);
      chk("prio_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      cyc();
      data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      probe();
      chk("prio_data_ok", 32'(data_data_ok), 32'd1);
      cyc();
      mem_data_ok = 0; mem_addr_ok = 1;
      probe();
      chk("prio_inst_after", 32'(inst_addr_ok), 32'd1);
      chk("prio_inst_addr", mem_addr, 32'hbfc00004);
      cyc();
      quiet(); mem_data_ok = 1;
      probe();
      chk("prio_inst_data_ok", 32'(inst_data_ok), 32'd1);

      // Starvation: both requesters and memory permanently ready.
      cyc();
      inst_req = 1; data_req = 1; data_wr = 0; mem_addr_ok = 1; mem_data_ok = 1;
      order = "";
      for (int i = 0; i < 20; i++) begin
         probe();
         if (data_addr_ok) order = {order, "D"};
         else if (inst_addr_ok) order = {order, "I"};
         if (i < 19) cyc();
      end
      total++;
      if (order != "DDDDIDDDDI") begin
         bad++;
         $display("FAIL starve_order: got %s, expected DDDDIDDDDI", order);
      end
      cyc();
      quiet();

      // Outstanding blocking.
      cyc();
      data_req = 1; data_addr = 32'h80002000; mem_addr_ok = 1;
      probe();
      chk("block_accept", 32'(data_addr_ok), 32'd1);
      for (int i = 0; i < 5; i++) begin
         cyc();
         data_req = i[0]; inst_req = !i[0]; mem_addr_ok = 1; mem_data_ok = 0;
         probe();
         chk("block_mem_req", 32'(mem_req), 32'd0);
         chk("block_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      end
      cyc();
      quiet(); mem_data_ok = 1; mem_rdata = 32'h0badf00d;
      probe();
      chk("block_owner_ok", 32'({inst_data_ok, data_data_ok}), 32'b01);
      chk("block_rdata", data_rdata, 32'h0badf00d);

      // Reset while an inst read is outstanding.
      cyc();
      quiet(); inst_req = 1; inst_addr = 32'hbfc00010; mem_addr_ok = 1;
      probe();
      chk("rst_accept", 32'(inst_addr_ok), 32'd1);
      cyc();
      quiet(); reset = 1;
      cyc();
      reset = 0;
      cyc();
      mem_data_ok = 1;
      probe();
      chk("rst_lost_resp", 32'({inst_data_ok, data_data_ok}), 32'd0);
      cyc();
      quiet(); data_req = 1; data_addr = 32'h80003000; mem_addr_ok = 1;
      probe();
      chk("rst_new_accept", 32'(data_addr_ok), 32'd1);
      cyc();
      quiet(); mem_data_ok = 1;
      probe();
      chk("rst_new_data_ok", 32'(data_data_ok), 32'd1);
      cyc();
      quiet();

      // Randomized traffic; requests are held until accepted.
      for (int c = 0; c < 3000; c++) begin
         cyc();
         reset = ($urandom_range(0, 199) == 0);
         if (!inst_req || acc_i) begin
            inst_req   = ($urandom_range(0, 2) != 0);
            inst_wr    = $urandom_range(0, 1) == 1;
            inst_size  = 2'($urandom_range(0, 2));
            inst_addr  = $urandom;
            inst_wstrb = 4'($urandom);
            inst_wdata = $urandom;
         end
         if (!data_req || acc_d) begin
            data_req   = ($urandom_range(0, 2) != 0);
            data_wr    = $urandom_range(0, 1) == 1;
            data_size  = 2'($urandom_range(0, 2));
            data_addr  = $urandom;
            data_wstrb = 4'($urandom);
            data_wdata = $urandom;
         end
         mem_addr_ok = $urandom_range(0, 1) == 1;
         mem_data_ok = $urandom_range(0, 9) < 4;
         mem_rdata   = $urandom;
      end
      cyc();
      reset = 0;
      quiet();
      probe();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (EXE/MEM stage), so the CPU core can sit behind a single bridge port. Keeps at most one transaction outstanding, routes the response back to the requester that owns it, and gives data accesses priority. A starvation counter guarantees instruction fetch progress.

## Interface
- STARVE_LIMIT, 4: number of consecutive data grants that may be issued while an inst request is pending; the next grant then goes to inst. Legal range is 1..15.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req / data_req  in  1  request valid. The requester holds the request and its fields stable until it sees addr_ok.
- inst_wr / data_wr  in  1  1 = write, 0 = read.
- inst_size / data_size  in  2  access size: 0 = byte, 1 = half, 2 = word.
- inst_addr / data_addr  in  32  byte address.
- inst_wstrb / data_wstrb  in  4  byte write strobes.
- inst_wdata / data_wdata  in  32  write data.
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle.
- inst_data_ok / data_data_ok  out  1  response for this requester this cycle.
- inst_rdata / data_rdata  out  32  read data; valid only when the matching data_ok is high.
- mem_req, mem_wr, mem_size[1:0], mem_addr[31:0], mem_wstrb[3:0], mem_wdata[31:0]  out  downstream request.
- mem_addr_ok  in  1  downstream accepted the request.
- mem_data_ok  in  1  downstream response.
- mem_rdata  in  32  downstream read data.

## Operation
- The arbiter has two states:
  - IDLE: nothing outstanding.
  - BUSY: one transaction accepted, waiting for mem_data_ok.
- Registered state:
  - state
  - owner (0 = inst, 1 = data)
  - starve_cnt (4 bits)
- Grant select, combinational, used only in IDLE:
  - If data_req and not (inst_req and starve_cnt == STARVE_LIMIT), grant data.
  - Otherwise, if inst_req, grant inst.
  - Otherwise, no grant.
- Request path in IDLE:
  - mem_req = granted requester's req.
  - All mem_* fields are muxed from the granted requester.
  - The granted requester's addr_ok = mem_addr_ok. The other requester's addr_ok = 0.
- Request path in BUSY:
  - mem_req = 0.
  - Both addr_ok outputs are 0.
  - mem_* fields are don't-care; drive them from the data requester.
- Transition IDLE -> BUSY on mem_req && mem_addr_ok. On that edge, owner is loaded with the granted requester.
- Starvation counter update on an accept edge:
  - If data was granted while inst_req was high, starve_cnt increments, saturating at STARVE_LIMIT.
  - Any inst grant clears starve_cnt to 0.
  - A data grant with inst_req low clears starve_cnt to 0.
- Response path in BUSY:
  - The owner's data_ok = mem_data_ok. The other requester's data_ok = 0.
  - Both rdata outputs are driven from mem_rdata at all times; consumers qualify them with data_ok.
  - BUSY -> IDLE on mem_data_ok.
- mem_data_ok arriving in IDLE is spurious (for example, the tail of a transaction cut off by reset). It is ignored and both data_ok outputs stay 0.
- Writes and reads are handled identically; a write still waits for mem_data_ok before returning to IDLE.

## Timing
- Reset (asynchronous) forces:
  - state = IDLE, owner = 0, starve_cnt = 0.
  - Consequently all addr_ok/data_ok outputs = 0 and mem_req = 0 while both req inputs are low.
- Request latency:
  - Request to downstream is combinational, with zero added cycles.
  - addr_ok is combinational from mem_addr_ok.
- Response latency: data_ok and rdata are combinational from mem_data_ok / mem_rdata.
- Minimum spacing between consecutive accepts is 2 cycles, one accept edge plus one data_ok edge:
  - mem_data_ok may arrive in the cycle right after accept.
  - A new accept is possible in the cycle after data_ok, not in the same cycle as data_ok.
- A request that is not yet accepted may be held any number of cycles. Grant may switch between requesters while mem_addr_ok is low. Priority is re-evaluated every IDLE cycle.
- Simultaneous inst_req and data_req in IDLE: exactly one addr_ok is asserted, never both.
- Reset asserted while BUSY returns the block to IDLE immediately. The lost response is not forwarded.

## Test plan
- Reset then idle: after reset, inst_req = data_req = 0 -> mem_req = 0 and all ok outputs 0 for 10 cycles; a mem_data_ok pulse injected in IDLE -> no data_ok on either side.
- Single fetch: inst_req, addr 0xbfc00000 read; mem_addr_ok in the same cycle; mem_data_ok with rdata 0x24080001 one cycle later -> inst_addr_ok at cycle 0, inst_data_ok with inst_rdata = 0x24080001 at cycle 1, data side silent throughout.
- Priority: both req high, data = write 0x80001000 with wstrb 0xF and wdata 0xdeadbeef -> mem_wr = 1, mem_addr = 0x80001000, data_addr_ok = 1, inst_addr_ok = 0. After data_data_ok, the inst request is granted on the next IDLE cycle.
- Starvation: inst_req and data_req held high continuously, memory always ready, STARVE_LIMIT = 4 -> grant order is D, D, D, D, I, D, D, D, D, I.
- Outstanding blocking: in BUSY, toggle data_req/inst_req and hold mem_data_ok low for 5 cycles -> mem_req = 0 and no addr_ok for 5 cycles; the response then goes only to the recorded owner.
- Reset mid-transaction: accept an inst read, assert reset before mem_data_ok, then deliver mem_data_ok after reset release -> inst_data_ok stays 0, state is IDLE, and a new data_req is accepted normally.
